// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampling UART receiver with 3-sample majority vote,
// false-start rejection, runtime parity / stop-bit selection and a
// valid/ready output register carrying parity, framing and overrun flags.
//
// Ports:
//   clk, rst           system clock, asynchronous active-high reset
//   baud_clk           oversample tick strobe (B_TICK pulses per bit)
//   baud_en            enables the shared baud tick generator during a frame
//   rx_data            asynchronous serial input, idles high
//   cfg_parity         00/11 none, 01 even, 10 odd (latched at frame start)
//   cfg_stop2          0 one stop bit, 1 two stop bits (latched at frame start)
//   out_data           received word, right-aligned, first line bit in LSB
//   out_valid          out_data and error flags hold a frame
//   out_ready          consumer accepts the held frame
//   parity_err         parity mismatch for the held frame
//   frame_err          a stop bit voted 0 for the held frame
//   overrun_err        one-cycle pulse when a completed frame is dropped
module uart_rx_cfg #(
  parameter int unsigned D_W    = 8,
  parameter int unsigned B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           baud_clk,
  output logic           baud_en,
  input  logic           rx_data,
  input  logic [1:0]     cfg_parity,
  input  logic           cfg_stop2,
  output logic [D_W-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           parity_err,
  output logic           frame_err,
  output logic           overrun_err
);

  localparam int unsigned TW = $clog2(B_TICK);
  localparam int unsigned IW = $clog2(D_W + 1);

  localparam logic [TW-1:0] T_S0  = TW'(B_TICK / 2 - 1);
  localparam logic [TW-1:0] T_S1  = TW'(B_TICK / 2);
  localparam logic [TW-1:0] T_S2  = TW'(B_TICK / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(B_TICK - 1);
  localparam logic [IW-1:0] I_END = IW'(D_W);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t         state;
  logic           sync1, sync2;
  logic [TW-1:0]  t_counter;
  logic [IW-1:0]  bit_idx;
  logic [D_W-1:0] shift;
  logic [1:0]     par_mode;
  logic           stop2;
  logic           stop_idx;
  logic           perr, ferr;
  logic           armed;
  logic           smp0, smp1;

  logic line, vote, vote_tick, bit_end, par_en, frame_ferr;

  assign line       = sync2;
  // Majority of the two stored samples and the live third sample.
  assign vote       = (smp0 & smp1) | (smp0 & line) | (smp1 & line);
  assign vote_tick  = baud_clk && (t_counter == T_S2);
  assign bit_end    = baud_clk && (t_counter == T_END);
  assign par_en     = ^par_mode;
  assign frame_ferr = ferr | ~vote;

  // Synchroniser, receive FSM and output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      sync1       <= 1'b1;
      sync2       <= 1'b1;
      t_counter   <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      par_mode    <= '0;
      stop2       <= 1'b0;
      stop_idx    <= 1'b0;
      perr        <= 1'b0;
      ferr        <= 1'b0;
      armed       <= 1'b1;
      smp0        <= 1'b0;
      smp1        <= 1'b0;
      baud_en     <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      parity_err  <= 1'b0;
      frame_err   <= 1'b0;
      overrun_err <= 1'b0;
    end else begin
      sync1       <= rx_data;
      sync2       <= sync1;
      overrun_err <= 1'b0;

      // Accepted frame leaves the register unless a new load overrides below.
      if (out_valid && out_ready) out_valid <= 1'b0;

      // Bit-time counter and the two early vote samples.
      if (baud_clk && state != IDLE) begin
        if (t_counter == T_END) t_counter <= '0;
        else                    t_counter <= t_counter + TW'(1);
        if (t_counter == T_S0) smp0 <= line;
        if (t_counter == T_S1) smp1 <= line;
      end

      case (state)
        IDLE: begin
          if (line) begin
            armed <= 1'b1;
          end else if (armed) begin
            state     <= START;
            baud_en   <= 1'b1;
            t_counter <= '0;
            par_mode  <= cfg_parity;
            stop2     <= cfg_stop2;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            bit_idx   <= '0;
            stop_idx  <= 1'b0;
          end
        end

        START: begin
          if (vote_tick && vote) begin
            // False start: the line was back high at mid-bit.
            state     <= IDLE;
            baud_en   <= 1'b0;
            t_counter <= '0;
          end else if (bit_end) begin
            state   <= DATA;
            bit_idx <= '0;
          end
        end

        DATA: begin
          if (vote_tick) begin
            shift   <= {vote, shift[D_W-1:1]};
            bit_idx <= bit_idx + IW'(1);
          end
          if (bit_end && bit_idx == I_END) state <= par_en ? PARITY : STOP;
        end

        PARITY: begin
          // Even mode (01) wants total XOR 0, odd mode (10) wants 1.
          if (vote_tick) perr <= ((^shift) ^ vote) != par_mode[1];
          if (bit_end) state <= STOP;
        end

        STOP: begin
          if (vote_tick) begin
            if (stop_idx == stop2) begin
              // Final stop vote: complete the frame without waiting for bit end.
              state     <= IDLE;
              baud_en   <= 1'b0;
              t_counter <= '0;
              armed     <= ~frame_ferr;
              if (!out_valid || out_ready) begin
                out_data   <= shift;
                parity_err <= perr;
                frame_err  <= frame_ferr;
                out_valid  <= 1'b1;
              end else begin
                overrun_err <= 1'b1;
              end
            end else begin
              stop_idx <= 1'b1;
              if (!vote) ferr <= 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: self-checking bench for uart_rx_cfg (D_W=8, B_TICK=16).
// Frames are built as line-level bit lists; expected words and flags are
// decoded from those bit lists by a behavioural reference model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

  localparam int unsigned D_W     = 8;
  localparam int unsigned B_TICK  = 16;
  localparam int unsigned BDIV    = 4;
  localparam int          BIT_CLK = B_TICK * BDIV;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           baud_clk;
  logic           baud_en;
  logic           rx_data = 1'b1;
  logic [1:0]     cfg_parity = 2'b00;
  logic           cfg_stop2 = 1'b0;
  logic [D_W-1:0] out_data;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic           parity_err;
  logic           frame_err;
  logic           overrun_err;

  uart_rx_cfg #(.D_W(D_W), .B_TICK(B_TICK)) dut (
    .clk(clk), .rst(rst), .baud_clk(baud_clk), .baud_en(baud_en),
    .rx_data(rx_data), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .parity_err(parity_err), .frame_err(frame_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  // Shared baud tick generator: one pulse every BDIV clocks while enabled.
  int unsigned bcnt;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bcnt     <= 0;
      baud_clk <= 1'b0;
    end else if (!baud_en) begin
      bcnt     <= 0;
      baud_clk <= 1'b0;
    end else if (bcnt == BDIV - 1) begin
      bcnt     <= 0;
      baud_clk <= 1'b1;
    end else begin
      bcnt     <= bcnt + 1;
      baud_clk <= 1'b0;
    end
  end

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } frm_t;

  // Output monitor: accepted frames, overrun pulses, valid-high cycles.
  frm_t got_q[$];
  int   ovr_cnt = 0;
  int   vcyc = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) got_q.push_back({out_data, parity_err, frame_err});
      if (overrun_err) ovr_cnt++;
      if (out_valid) vcyc++;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;
  int rd = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-level frame: start, data LSB first, optional parity, stop bit(s).
  function automatic void build(input logic [7:0] d, input logic [1:0] pm, input logic s2,
                                input logic pflip, input logic [1:0] stops,
                                output logic [15:0] bits, output int n);
    bits = '0;
    n = 0;
    bits[n] = 1'b0; n++;
    for (int i = 0; i < int'(D_W); i++) begin bits[n] = d[i]; n++; end
    if (pm == 2'b01 || pm == 2'b10) begin
      bits[n] = (^d) ^ (pm == 2'b10) ^ pflip; n++;
    end
    bits[n] = stops[0]; n++;
    if (s2) begin bits[n] = stops[1]; n++; end
  endfunction

  // Reference decode of a transmitted bit list.
  function automatic frm_t model(input logic [15:0] bits, input logic [1:0] pm, input logic s2);
    frm_t f;
    int   idx;
    f.d  = bits[D_W:1];
    f.pe = 1'b0;
    idx  = D_W + 1;
    if (pm == 2'b01 || pm == 2'b10) begin
      f.pe = ((^f.d) ^ bits[idx]) != (pm == 2'b10);
      idx++;
    end
    f.fe = ~bits[idx];
    if (s2) f.fe = f.fe | ~bits[idx + 1];
    return f;
  endfunction

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #2; end
  endtask

  task automatic idle(input int n);
    @(posedge clk); #2;
    rx_data = 1'b1;
    cyc(n);
  endtask

  // Drive a bit list; optional one-tick inversion inside bit 'glitch' vote
  // window; optionally scramble the config mid-frame.
  task automatic send(input logic [15:0] bits, input int n, input int glitch, input bit scramble);
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        @(posedge clk); #2;
        if (b == glitch && c >= 36 && c < 40) rx_data = ~bits[b];
        else                                  rx_data = bits[b];
        if (scramble && b == 2 && c == 0) begin
          cfg_parity = 2'($urandom);
          cfg_stop2  = 1'($urandom);
        end
      end
    end
  endtask

  task automatic expect_one(input string name, input frm_t e);
    int w = 0;
    frm_t g;
    while (got_q.size() <= rd && w < 300) begin @(negedge clk); w++; end
    if (got_q.size() <= rd) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s timeout: got no frame expected data %0h", name, e.d);
    end else begin
      g = got_q[rd];
      rd++;
      chk({name, " data"}, 32'(g.d), 32'(e.d));
      chk({name, " parity_err"}, 32'(g.pe), 32'(e.pe));
      chk({name, " frame_err"}, 32'(g.fe), 32'(e.fe));
    end
    cyc(10);
    chk({name, " frame count"}, 32'(got_q.size()), 32'(rd));
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic [1:0] pm,
                           input logic s2, input logic pflip, input logic [1:0] stops,
                           input int glitch, input frm_t e);
    logic [15:0] bits;
    int n;
    cfg_parity = pm;
    cfg_stop2  = s2;
    build(d, pm, s2, pflip, stops, bits, n);
    send(bits, n, glitch, 1'b0);
    idle(20);
    expect_one(name, e);
  endtask

  typedef struct {
    logic [7:0] data;
    logic [1:0] pm;
    logic       s2;
    logic       pflip;
    logic [1:0] stops;
    int         glitch;
    logic [7:0] exp_d;
    logic       exp_pe;
    logic       exp_fe;
  } vec_t;

  vec_t vt[10];

  initial begin : watchdog
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic [15:0] bits;
    int          n;
    int          v0, o0;
    frm_t        e;

    vt[0] = '{8'hA5, 2'b00, 1'b0, 1'b0, 2'b11, -1, 8'hA5, 1'b0, 1'b0};
    vt[1] = '{8'h3C, 2'b01, 1'b0, 1'b0, 2'b11, -1, 8'h3C, 1'b0, 1'b0};
    vt[2] = '{8'h3C, 2'b01, 1'b0, 1'b1, 2'b11, -1, 8'h3C, 1'b1, 1'b0};
    vt[3] = '{8'hC3, 2'b10, 1'b0, 1'b0, 2'b11, -1, 8'hC3, 1'b0, 1'b0};
    vt[4] = '{8'h01, 2'b10, 1'b0, 1'b1, 2'b11, -1, 8'h01, 1'b1, 1'b0};
    vt[5] = '{8'h5A, 2'b00, 1'b1, 1'b0, 2'b01, -1, 8'h5A, 1'b0, 1'b1};
    vt[6] = '{8'h5A, 2'b00, 1'b1, 1'b0, 2'b11, -1, 8'h5A, 1'b0, 1'b0};
    vt[7] = '{8'h96, 2'b00, 1'b0, 1'b0, 2'b11,  3, 8'h96, 1'b0, 1'b0};
    vt[8] = '{8'h6B, 2'b00, 1'b0, 1'b0, 2'b11,  0, 8'h6B, 1'b0, 1'b0};
    vt[9] = '{8'hFE, 2'b11, 1'b0, 1'b0, 2'b11, -1, 8'hFE, 1'b0, 1'b0};

    // Reset state.
    @(negedge clk); @(negedge clk);
    chk("reset out_data", 32'(out_data), 32'h0);
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset parity_err", 32'(parity_err), 32'h0);
    chk("reset frame_err", 32'(frame_err), 32'h0);
    chk("reset overrun_err", 32'(overrun_err), 32'h0);
    chk("reset baud_en", 32'(baud_en), 32'h0);
    @(posedge clk); #2;
    rst = 1'b0;
    idle(20);

    // Table-driven frames; the first also checks a single-cycle out_valid.
    for (int i = 0; i < 10; i++) begin
      v0 = vcyc;
      run_frame($sformatf("vec%0d", i), vt[i].data, vt[i].pm, vt[i].s2, vt[i].pflip,
                vt[i].stops, vt[i].glitch, '{vt[i].exp_d, vt[i].exp_pe, vt[i].exp_fe});
      if (i == 0) chk("vec0 valid cycles", 32'(vcyc - v0), 32'd1);
    end

    // False start: line low for 4 ticks only.
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    @(posedge clk); #2;
    rx_data = 1'b0;
    cyc(4 * BDIV);
    chk("false start baud_en high", 32'(baud_en), 32'd1);
    rx_data = 1'b1;
    cyc(100);
    chk("false start baud_en low", 32'(baud_en), 32'd0);
    chk("false start no frame", 32'(got_q.size()), 32'(rd));
    run_frame("after false start", 8'h81, 2'b00, 1'b0, 1'b0, 2'b11, -1, '{8'h81, 1'b0, 1'b0});

    // Break: stop bit 0 and line held low for 3 bit times.
    build(8'h55, 2'b00, 1'b0, 1'b0, 2'b00, bits, n);
    send(bits, n, -1, 1'b0);
    cyc(3 * BIT_CLK);
    expect_one("break frame", '{8'h55, 1'b0, 1'b1});
    chk("break baud_en idle", 32'(baud_en), 32'd0);
    idle(40);
    chk("break no extra frame", 32'(got_q.size()), 32'(rd));
    run_frame("after break", 8'h12, 2'b00, 1'b0, 1'b0, 2'b11, -1, '{8'h12, 1'b0, 1'b0});

    // Randomised frames against the reference model; config scrambled mid-frame.
    for (int i = 0; i < 20; i++) begin
      logic [7:0] d;
      logic [1:0] pm;
      logic       s2, pf;
      logic [1:0] st;
      d  = 8'($urandom);
      pm = 2'($urandom);
      s2 = 1'($urandom);
      pf = ($urandom_range(0, 3) == 0);
      st[0] = ($urandom_range(0, 3) != 0);
      st[1] = ($urandom_range(0, 3) != 0);
      cfg_parity = pm;
      cfg_stop2  = s2;
      build(d, pm, s2, pf, st, bits, n);
      e = model(bits, pm, s2);
      send(bits, n, -1, 1'b1);
      idle(20);
      expect_one($sformatf("rand%0d", i), e);
    end

    // Overrun: consumer stalled across two frames.
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    out_ready  = 1'b0;
    o0 = ovr_cnt;
    build(8'h11, 2'b00, 1'b0, 1'b0, 2'b11, bits, n);
    send(bits, n, -1, 1'b0);
    idle(20);
    build(8'h22, 2'b00, 1'b0, 1'b0, 2'b11, bits, n);
    send(bits, n, -1, 1'b0);
    idle(20);
    @(negedge clk);
    chk("overrun held data", 32'(out_data), 32'h11);
    chk("overrun held valid", 32'(out_valid), 32'd1);
    chk("overrun pulse count", 32'(ovr_cnt - o0), 32'd1);
    @(posedge clk); #2;
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready cycle valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    chk("valid drop after ready", 32'(out_valid), 32'd0);
    rd = got_q.size();

    // Reset in the middle of the data bits.
    @(posedge clk); #2;
    rx_data = 1'b0;
    cyc(2 * BIT_CLK + 30);
    chk("mid-data baud_en", 32'(baud_en), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset out_data", 32'(out_data), 32'h0);
    chk("mid reset out_valid", 32'(out_valid), 32'd0);
    chk("mid reset baud_en", 32'(baud_en), 32'd0);
    chk("mid reset errs", 32'({parity_err, frame_err, overrun_err}), 32'd0);
    @(posedge clk); #2;
    rx_data = 1'b1;
    cyc(3);
    rst = 1'b0;
    idle(20);
    chk("post reset no frame", 32'(got_q.size()), 32'(rd));
    run_frame("after reset", 8'hF0, 2'b00, 1'b0, 1'b0, 2'b11, -1, '{8'hF0, 1'b0, 1'b0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
